// File: rtl/ps2_mouse_tracker_if.sv
// Byte stream from the PS/2 receiver: one data byte qualified by a one-cycle strobe.
interface ps2_mouse_tracker_if;
  logic [7:0] received_data;
  logic       received_data_en;

  modport master (output received_data, output received_data_en);
  modport slave  (input  received_data, input  received_data_en);
endinterface

// File: rtl/ps2_mouse_tracker.sv
// Frames 3-byte PS/2 mouse packets, decodes buttons and deltas, and keeps a
// clamped absolute cursor position; drops ACK/self-test bytes and resyncs on stalls.
module ps2_mouse_tracker #(
  parameter int X_MAX         = 639,
  parameter int Y_MAX         = 479,
  parameter int X_INIT        = 320,
  parameter int Y_INIT        = 240,
  parameter int RESYNC_CYCLES = 1000000
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  ps2_mouse_tracker_if.slave rx,
  output logic [9:0]         pos_x,
  output logic [9:0]         pos_y,
  output logic [2:0]         buttons,
  output logic [8:0]         dx,
  output logic [8:0]         dy,
  output logic               packet_valid,
  output logic               sync_error
);

  localparam int GAP_W = $clog2(RESYNC_CYCLES + 1);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(RESYNC_CYCLES - 1);
  localparam logic signed [11:0] X_LIM   = 12'(X_MAX);
  localparam logic signed [11:0] Y_LIM   = 12'(Y_MAX);

  typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2} state_t;

  state_t            state, next_state;
  logic [GAP_W-1:0]  gap;
  logic              timeout;
  logic              latch_b0, latch_b1, commit, drop;

  // Fields of the first packet byte; bit 3 is only a framing marker.
  logic              ovf_y, ovf_x, sign_y, sign_x;
  logic [2:0]        btn_raw;
  logic [7:0]        b1;

  logic [8:0]        dx_new, dy_new;
  logic signed [11:0] sum_x, sum_y;
  logic [9:0]        next_x, next_y;

  assign timeout = (gap == GAP_LAST);

  always_comb begin
    next_state = state;
    latch_b0   = 1'b0;
    latch_b1   = 1'b0;
    commit     = 1'b0;
    drop       = 1'b0;
    case (state)
      WAIT_B0: begin
        if (rx.received_data_en) begin
          if (rx.received_data == 8'hFA || rx.received_data == 8'hAA) begin
            next_state = WAIT_B0;
          end else if (!rx.received_data[3]) begin
            drop = 1'b1;
          end else begin
            latch_b0   = 1'b1;
            next_state = WAIT_B1;
          end
        end
      end
      WAIT_B1: begin
        if (rx.received_data_en) begin
          latch_b1   = 1'b1;
          next_state = WAIT_B2;
        end else if (timeout) begin
          drop       = 1'b1;
          next_state = WAIT_B0;
        end
      end
      WAIT_B2: begin
        if (rx.received_data_en) begin
          commit     = 1'b1;
          next_state = WAIT_B0;
        end else if (timeout) begin
          drop       = 1'b1;
          next_state = WAIT_B0;
        end
      end
      default: next_state = WAIT_B0;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= WAIT_B0;
    end else begin
      state <= next_state;
    end
  end

  // A byte always beats a coinciding timeout because the strobe clears the count.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      gap <= '0;
    end else if (rx.received_data_en || state == WAIT_B0 || timeout) begin
      gap <= '0;
    end else begin
      gap <= gap + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      ovf_y   <= 1'b0;
      ovf_x   <= 1'b0;
      sign_y  <= 1'b0;
      sign_x  <= 1'b0;
      btn_raw <= 3'd0;
      b1      <= 8'd0;
    end else begin
      if (latch_b0) begin
        ovf_y   <= rx.received_data[7];
        ovf_x   <= rx.received_data[6];
        sign_y  <= rx.received_data[5];
        sign_x  <= rx.received_data[4];
        btn_raw <= rx.received_data[2:0];
      end
      if (latch_b1) begin
        b1 <= rx.received_data;
      end
    end
  end

  // The third byte is used straight off the bus in its strobe cycle.
  always_comb begin
    dx_new = ovf_x ? 9'd0 : {sign_x, b1};
    dy_new = ovf_y ? 9'd0 : {sign_y, rx.received_data};
    sum_x  = $signed({2'b00, pos_x}) + $signed({{3{dx_new[8]}}, dx_new});
    sum_y  = $signed({2'b00, pos_y}) - $signed({{3{dy_new[8]}}, dy_new});

    if (sum_x < 12'sd0) begin
      next_x = 10'd0;
    end else if (sum_x > X_LIM) begin
      next_x = 10'(X_MAX);
    end else begin
      next_x = sum_x[9:0];
    end

    if (sum_y < 12'sd0) begin
      next_y = 10'd0;
    end else if (sum_y > Y_LIM) begin
      next_y = 10'(Y_MAX);
    end else begin
      next_y = sum_y[9:0];
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      pos_x        <= 10'(X_INIT);
      pos_y        <= 10'(Y_INIT);
      buttons      <= 3'd0;
      dx           <= 9'd0;
      dy           <= 9'd0;
      packet_valid <= 1'b0;
      sync_error   <= 1'b0;
    end else begin
      packet_valid <= commit;
      sync_error   <= drop;
      if (commit) begin
        buttons <= btn_raw;
        dx      <= dx_new;
        dy      <= dy_new;
        pos_x   <= next_x;
        pos_y   <= next_y;
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Self-checking bench: constant vector table, targeted sequences, and random bytes against a packet-level model.
module tb_ps2_mouse_tracker;

  localparam int R      = 40;
  localparam int X_MAX  = 639;
  localparam int Y_MAX  = 479;
  localparam int X_INIT = 320;
  localparam int Y_INIT = 240;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic [9:0] pos_x, pos_y;
  logic [2:0] buttons;
  logic [8:0] dx, dy;
  logic       packet_valid, sync_error;

  ps2_mouse_tracker_if rx_if ();

  ps2_mouse_tracker #(
    .X_MAX(X_MAX), .Y_MAX(Y_MAX), .X_INIT(X_INIT), .Y_INIT(Y_INIT), .RESYNC_CYCLES(R)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .rx(rx_if),
    .pos_x(pos_x),
    .pos_y(pos_y),
    .buttons(buttons),
    .dx(dx),
    .dy(dy),
    .packet_valid(packet_valid),
    .sync_error(sync_error)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [7:0] data;
    logic       pv;
    logic       se;
    int         x;
    int         y;
    logic [2:0] btn;
    int         dxv;
    int         dyv;
  } vec_t;

  vec_t vecs[24];

  int errors = 0;
  int checks = 0;

  logic [7:0] pkt[$];
  int         mdl_x, mdl_y, mdl_dx, mdl_dy;
  logic [2:0] mdl_btn;
  logic       mdl_pv, mdl_se;

  function automatic int clampInt(int v, int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic checkVal(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkOutput(string tag, logic pv, logic se, int x, int y,
                             logic [2:0] btn, int dxv, int dyv);
    checkVal({tag, ".packet_valid"}, int'(packet_valid), int'(pv));
    checkVal({tag, ".sync_error"}, int'(sync_error), int'(se));
    checkVal({tag, ".pos_x"}, int'(pos_x), x);
    checkVal({tag, ".pos_y"}, int'(pos_y), y);
    checkVal({tag, ".buttons"}, int'(buttons), int'(btn));
    checkVal({tag, ".dx"}, int'($signed(dx)), dxv);
    checkVal({tag, ".dy"}, int'($signed(dy)), dyv);
  endtask

  task automatic modelReset();
    pkt.delete();
    mdl_x   = X_INIT;
    mdl_y   = Y_INIT;
    mdl_dx  = 0;
    mdl_dy  = 0;
    mdl_btn = 3'd0;
    mdl_pv  = 1'b0;
    mdl_se  = 1'b0;
  endtask

  // Packet-level view: a byte either starts, extends, or completes a packet.
  task automatic applyModel(logic [7:0] b);
    logic [7:0] h;
    mdl_pv = 1'b0;
    mdl_se = 1'b0;
    if (pkt.size() == 0) begin
      if (b == 8'hFA || b == 8'hAA) begin
        mdl_se = 1'b0;
      end else if (!b[3]) begin
        mdl_se = 1'b1;
      end else begin
        pkt.push_back(b);
      end
    end else begin
      pkt.push_back(b);
      if (pkt.size() == 3) begin
        h = pkt[0];
        mdl_dx  = h[6] ? 0 : (h[4] ? int'(pkt[1]) - 256 : int'(pkt[1]));
        mdl_dy  = h[7] ? 0 : (h[5] ? int'(pkt[2]) - 256 : int'(pkt[2]));
        mdl_btn = h[2:0];
        mdl_x   = clampInt(mdl_x + mdl_dx, X_MAX);
        mdl_y   = clampInt(mdl_y - mdl_dy, Y_MAX);
        mdl_pv  = 1'b1;
        pkt.delete();
      end
    end
  endtask

  task automatic applyStimulus(logic [7:0] b);
    @(negedge CLOCK_50);
    rx_if.received_data    = b;
    rx_if.received_data_en = 1'b1;
    @(negedge CLOCK_50);
    rx_if.received_data_en = 1'b0;
    rx_if.received_data    = 8'h00;
    applyModel(b);
  endtask

  task automatic checkQuiet(string tag);
    @(negedge CLOCK_50);
    checkVal({tag, ".pv_one_cycle"}, int'(packet_valid), 0);
    checkVal({tag, ".se_one_cycle"}, int'(sync_error), 0);
  endtask

  task automatic sendModel(logic [7:0] b, string tag);
    applyStimulus(b);
    checkOutput(tag, mdl_pv, mdl_se, mdl_x, mdl_y, mdl_btn, mdl_dx, mdl_dy);
    checkQuiet(tag);
  endtask

  task automatic resetDut(string tag);
    @(negedge CLOCK_50);
    reset                  = 1'b1;
    rx_if.received_data_en = 1'b0;
    @(negedge CLOCK_50);
    reset = 1'b0;
    modelReset();
    checkOutput(tag, 1'b0, 1'b0, X_INIT, Y_INIT, 3'd0, 0, 0);
  endtask

  // Last strobe was sampled two negedges ago; the drop pulse is due R-1 negedges later.
  task automatic waitTimeout(string tag);
    int  when;
    bit  seen;
    bit  bad_pv;
    when   = -1;
    seen   = 1'b0;
    bad_pv = 1'b0;
    for (int k = 1; k <= R + 20 && !seen; k++) begin
      @(negedge CLOCK_50);
      if (packet_valid) bad_pv = 1'b1;
      if (sync_error) begin
        seen = 1'b1;
        when = k;
      end
    end
    checkVal({tag, ".timeout_cycle"}, when, R - 1);
    checkVal({tag, ".no_packet"}, int'(bad_pv), 0);
    pkt.delete();
    checkVal({tag, ".pos_x_held"}, int'(pos_x), mdl_x);
    checkQuiet(tag);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{8'hFA, 1'b0, 1'b0, 320, 240, 3'd0, 0, 0};
    vecs[1]  = '{8'hAA, 1'b0, 1'b0, 320, 240, 3'd0, 0, 0};
    vecs[2]  = '{8'h09, 1'b0, 1'b0, 320, 240, 3'd0, 0, 0};
    vecs[3]  = '{8'h05, 1'b0, 1'b0, 320, 240, 3'd0, 0, 0};
    vecs[4]  = '{8'h03, 1'b1, 1'b0, 325, 237, 3'd1, 5, 3};
    vecs[5]  = '{8'h00, 1'b0, 1'b1, 325, 237, 3'd1, 5, 3};
    vecs[6]  = '{8'h18, 1'b0, 1'b0, 325, 237, 3'd1, 5, 3};
    vecs[7]  = '{8'h00, 1'b0, 1'b0, 325, 237, 3'd1, 5, 3};
    vecs[8]  = '{8'h00, 1'b1, 1'b0, 69, 237, 3'd0, -256, 0};
    vecs[9]  = '{8'h08, 1'b0, 1'b0, 69, 237, 3'd0, -256, 0};
    vecs[10] = '{8'hFF, 1'b0, 1'b0, 69, 237, 3'd0, -256, 0};
    vecs[11] = '{8'h00, 1'b1, 1'b0, 324, 237, 3'd0, 255, 0};
    vecs[12] = '{8'h48, 1'b0, 1'b0, 324, 237, 3'd0, 255, 0};
    vecs[13] = '{8'hFF, 1'b0, 1'b0, 324, 237, 3'd0, 255, 0};
    vecs[14] = '{8'h10, 1'b1, 1'b0, 324, 221, 3'd0, 0, 16};
    vecs[15] = '{8'h28, 1'b0, 1'b0, 324, 221, 3'd0, 0, 16};
    vecs[16] = '{8'h00, 1'b0, 1'b0, 324, 221, 3'd0, 0, 16};
    vecs[17] = '{8'h01, 1'b1, 1'b0, 324, 476, 3'd0, 0, -255};
    vecs[18] = '{8'h28, 1'b0, 1'b0, 324, 476, 3'd0, 0, -255};
    vecs[19] = '{8'h00, 1'b0, 1'b0, 324, 476, 3'd0, 0, -255};
    vecs[20] = '{8'h00, 1'b1, 1'b0, 324, 479, 3'd0, 0, -256};
    vecs[21] = '{8'h0F, 1'b0, 1'b0, 324, 479, 3'd0, 0, -256};
    vecs[22] = '{8'hFA, 1'b0, 1'b0, 324, 479, 3'd0, 0, -256};
    vecs[23] = '{8'hAA, 1'b1, 1'b0, 574, 309, 3'd7, 250, 170};

    rx_if.received_data    = 8'h00;
    rx_if.received_data_en = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    resetDut("reset");

    for (int i = 0; i < 24; i++) begin
      applyStimulus(vecs[i].data);
      checkOutput($sformatf("vec%0d", i), vecs[i].pv, vecs[i].se, vecs[i].x, vecs[i].y,
                  vecs[i].btn, vecs[i].dxv, vecs[i].dyv);
      checkQuiet($sformatf("vec%0d", i));
    end

    resetDut("clampx_reset");
    sendModel(8'h18, "clampx_a0");
    sendModel(8'h00, "clampx_a1");
    sendModel(8'h00, "clampx_a2");
    checkVal("clampx_pos_64", int'(pos_x), 64);
    sendModel(8'h18, "clampx_b0");
    sendModel(8'h00, "clampx_b1");
    sendModel(8'h00, "clampx_b2");
    checkVal("clampx_pos_0", int'(pos_x), 0);
    for (int k = 0; k < 3; k++) begin
      sendModel(8'h08, "clampx_up0");
      sendModel(8'hFF, "clampx_up1");
      sendModel(8'h00, "clampx_up2");
    end
    checkVal("clampx_pos_max", int'(pos_x), 639);

    resetDut("ovf_reset");
    sendModel(8'h48, "ovf0");
    sendModel(8'hFF, "ovf1");
    sendModel(8'h10, "ovf2");
    checkVal("ovf_dx_zero", int'($signed(dx)), 0);
    checkVal("ovf_pos_y", int'(pos_y), 224);

    resetDut("resync_reset");
    sendModel(8'h00, "resync_bad");
    sendModel(8'h09, "resync_p0");
    sendModel(8'h05, "resync_p1");
    waitTimeout("resync_b2");
    sendModel(8'h0A, "resync_q0");
    waitTimeout("resync_b1");
    sendModel(8'h08, "resync_ok0");
    sendModel(8'h01, "resync_ok1");
    sendModel(8'h01, "resync_ok2");
    checkVal("resync_dy", int'($signed(dy)), 1);

    resetDut("midreset_pre");
    sendModel(8'h09, "midreset_p0");
    sendModel(8'h05, "midreset_p1");
    resetDut("midreset_reset");
    sendModel(8'h08, "midreset_q0");
    sendModel(8'h02, "midreset_q1");
    sendModel(8'h00, "midreset_q2");
    checkVal("midreset_pos_x", int'(pos_x), 322);
    checkVal("midreset_pos_y", int'(pos_y), 240);

    resetDut("rnd_reset");
    for (int i = 0; i < 300; i++) begin
      logic [7:0] b;
      int         r;
      r = int'($urandom_range(0, 9));
      b = 8'($urandom);
      if (r == 0) b = 8'hFA;
      else if (r == 1) b = 8'hAA;
      else if (r < 7) b = b | 8'h08;
      sendModel(b, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
